// File: rtl/instr_encoder.sv
// RV32 instruction-word encoder: packs request fields by format, flags
// immediates that do not fit, and buffers results in a 2-entry FIFO.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] enc_count
);

  typedef enum logic [2:0] {
    FMT_I   = 3'b000,
    FMT_S   = 3'b001,
    FMT_B   = 3'b010,
    FMT_U   = 3'b011,
    FMT_J   = 3'b100,
    FMT_FLW = 3'b101,
    FMT_FSW = 3'b110,
    FMT_R   = 3'b111
  } fmt_e;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } entry_t;

  fmt_e   fmt_sel;
  logic   fits_i;
  logic   fits_b;
  logic   fits_j;
  entry_t enc;

  assign fmt_sel = fmt_e'(fmt);

  // An immediate fits when every bit above the field's sign bit copies it.
  assign fits_i = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_b = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits_j = (&imm[31:20]) | ~(|imm[31:20]);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    enc = '0;
    case (fmt_sel)
      FMT_I, FMT_FLW: begin
        enc.instr = {imm[11:0], rs1, funct3, rd, opcode};
        enc.err   = ~fits_i;
      end
      FMT_S, FMT_FSW: begin
        enc.instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc.err   = ~fits_i;
      end
      FMT_B: begin
        enc.instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc.err   = imm[0] | ~fits_b;
      end
      FMT_U: begin
        enc.instr = {imm[31:12], rd, opcode};
        enc.err   = |imm[11:0];
      end
      FMT_J: begin
        enc.instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc.err   = imm[0] | ~fits_j;
      end
      FMT_R: begin
        enc.instr = {funct7, rs2, rs1, funct3, rd, opcode};
        enc.err   = 1'b0;
      end
      default: enc = '0;
    endcase
  end

  state_e      state_q, state_d;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  logic [15:0] count_q, count_d;
  logic        push;
  logic        pop;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_instr = head_q.instr;
  assign out_err   = head_q.err;
  assign enc_count = count_q;

  // head always holds the oldest entry; tail is only live in FULL.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = enc;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            tail_d  = enc;
            state_d = FULL;
          end
          2'b01:   state_d = EMPTY;
          2'b11:   head_d  = enc;
          default: state_d = ONE;
        endcase
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (pop) count_d = count_q + 16'd1;
  end

  // NOTE: the two storage entries are reset as well, because out_instr and
  // out_err are driven straight from head and must read zero under reset.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // its pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
